// File: rtl/cv32e40n_vstream_lsu.sv
// -----------------------------------------------------------------------------
// cv32e40n_vstream_lsu
//
// Strided word load/store streaming engine for the NVPE. It sits as master 2 on
// the data crossbar. One command (base, signed stride, length, direction) is
// expanded into a sequence of 32-bit OBI-style bus transactions.
//   - Loads: response data is buffered in a small registered read FIFO and
//     handed out on the rd_* valid/ready stream.
//   - Stores: write data is taken from the wr_* valid/ready stream. A word is
//     consumed in the same cycle its bus request is granted.
// In-flight requests plus buffered load words never exceed MAX_OUTST. Because
// of this, a bus response always finds room in the FIFO and rvalid is never
// back-pressured.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cmd_*                     command handshake (accepted in IDLE only)
//   rd_valid_o/ready_i/data_o load data stream
//   wr_valid_i/ready_o/data_i store data stream
//   done_o, err_o             one-cycle completion pulse; err_o flags a
//                             rejected (misaligned) command
//   busy_o                    engine not idle
//   mem_master_sel_o          crossbar routes the slave to this master
//   data_*                    OBI-style bus master (mm_ram handshake)
// -----------------------------------------------------------------------------
module cv32e40n_vstream_lsu #(
    parameter int LEN_W     = 8,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [31:0]      cmd_stride_i,
    input  logic [LEN_W-1:0] cmd_len_i,

    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      rd_data_o,

    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_data_i,

    output logic             done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             mem_master_sel_o,

    output logic             data_req_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    input  logic [31:0]      data_rdata_i
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cur_addr_q, cur_addr_d;
    logic [31:0]        stride_q, stride_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      fcnt_q, fcnt_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic               cmd_ready_q;
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [31:0]        fifo_q [MAX_OUTST];

    logic [CW:0]        credit_used;
    logic               req;
    logic               gnt_ok;
    logic               rsp_ok;
    logic               push;
    logic               pop;

    // Credits are shared between requests still on the bus and load words
    // sitting in the FIFO; a pop can only free credit, so req never drops
    // while it waits for a grant (store req also depends on wr_valid_i, which
    // the producer holds until consumed).
    assign credit_used = {1'b0, outst_q} + {1'b0, fcnt_q};

    assign req = (state_q == S_ISSUE) && (remaining_q != '0) &&
                 (credit_used < (CW+1)'(MAX_OUTST)) && (!we_q || wr_valid_i);
    assign gnt_ok = req && data_gnt_i;

    // Responses with nothing outstanding (e.g. left over from before a reset)
    // are dropped rather than corrupting the counters.
    assign rsp_ok = data_rvalid_i && (outst_q != '0);
    assign push   = rsp_ok && !we_q;
    assign pop    = (fcnt_q != '0) && rd_ready_i;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        we_d        = we_q;
        err_d       = err_q;
        outst_d     = outst_q;
        fcnt_d      = fcnt_q;

        case ({gnt_ok, rsp_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    if ((cmd_addr_i[1:0] != 2'b00) || (cmd_stride_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_len_i == '0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d       = 1'b0;
                        cur_addr_d  = cmd_addr_i;
                        stride_d    = cmd_stride_i;
                        remaining_d = cmd_len_i;
                        we_d        = cmd_we_i;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (gnt_ok) begin
                    cur_addr_d  = cur_addr_q + stride_q;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((outst_q == '0) && (fcnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            outst_q     <= '0;
            fcnt_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            outst_q     <= outst_d;
            fcnt_q      <= fcnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            // Registered so that it reads 0 while reset is asserted.
            cmd_ready_q <= (state_d == S_IDLE);
            if (push) begin
                wptr_q <= (wptr_q == PW'(MAX_OUTST-1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PW'(MAX_OUTST-1)) ? '0 : rptr_q + 1'b1;
            end
        end
    end

    // FIFO storage holds data only; occupancy is tracked by fcnt_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= data_rdata_i;
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign rd_valid_o       = (fcnt_q != '0);
    assign rd_data_o        = rd_valid_o ? fifo_q[rptr_q] : 32'h0;
    assign wr_ready_o       = gnt_ok && we_q;
    assign done_o           = (state_q == S_DONE);
    assign err_o            = (state_q == S_DONE) && err_q;
    assign busy_o           = (state_q != S_IDLE);
    assign mem_master_sel_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    assign data_req_o   = req;
    assign data_we_o    = req && we_q;
    assign data_be_o    = req ? 4'hF : 4'h0;
    assign data_addr_o  = req ? cur_addr_q : 32'h0;
    assign data_wdata_o = (req && we_q) ? wr_data_i : 32'h0;

`ifndef SYNTHESIS
    a_rvalid_with_outst: assert property (
        @(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> (outst_q != '0)
    ) else $error("vstream_lsu: bus response with nothing outstanding");
`endif

endmodule

// File: tb/tb_cv32e40n_vstream_lsu.sv
// -----------------------------------------------------------------------------
// tb_cv32e40n_vstream_lsu
//
// Directed bench for the strided load/store streaming engine. A behavioural
// memory answers every granted request one cycle later; an observer on the
// falling edge records grants, read handshakes, responses and done pulses,
// which each scenario task compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cv32e40n_vstream_lsu;

    localparam int LEN_W     = 8;
    localparam int MAX_OUTST = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_we = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [31:0]      cmd_stride = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [31:0]      rd_data;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [31:0]      wr_data = '0;
    logic             done, err, busy, msel;
    logic             data_req, data_gnt, data_we;
    logic             data_rvalid;
    logic [3:0]       data_be;
    logic [31:0]      data_addr, data_wdata, data_rdata;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic gnt_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_gnt = data_req & (gnt_stall ? cyc[0] : 1'b1);

    cv32e40n_vstream_lsu #(.LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_stride_i(cmd_stride), .cmd_len_i(cmd_len),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .done_o(done), .err_o(err), .busy_o(busy), .mem_master_sel_o(msel),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
    );

    // Memory: preloaded read image (mem), store results (wmem).
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] wmem [logic [31:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rvalid <= 1'b0;
            data_rdata  <= 32'h0;
        end else begin
            data_rvalid <= data_req && data_gnt;
            if (data_req && data_gnt) begin
                if (data_we) wmem[data_addr] = data_wdata;
                else data_rdata <= mem.exists(data_addr) ? mem[data_addr] : (32'hDEAD_0000 ^ data_addr);
            end
        end
    end

    // Observer
    logic [31:0] addr_log[$];
    logic [3:0]  be_log[$];
    int          gnt_cyc[$];
    logic [31:0] rd_log[$];
    int          rd_cyc[$];
    int done_cnt = 0, done_cyc = -1, acc_cyc = -1, last_rv_cyc = -1, rv_cnt = 0;
    int wr_bad = 0, stab_err = 0;
    logic done_err = 1'b0;
    logic stall_q = 1'b0, stall_we = 1'b0;
    logic [31:0] stall_addr = '0, stall_wd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (data_req && data_gnt) begin
                addr_log.push_back(data_addr);
                be_log.push_back(data_be);
                gnt_cyc.push_back(cyc);
            end
            if (stall_q && (!data_req || data_addr != stall_addr ||
                            data_we != stall_we || data_wdata != stall_wd)) stab_err++;
            stall_q    = data_req && !data_gnt;
            stall_addr = data_addr;
            stall_we   = data_we;
            stall_wd   = data_wdata;
            if (data_rvalid) begin
                last_rv_cyc = cyc;
                rv_cnt++;
            end
            if (rd_valid && rd_ready) begin
                rd_log.push_back(rd_data);
                rd_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
            end
            if (wr_ready && !(data_req && data_gnt && data_we)) wr_bad++;
        end
    end

    task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] s,
                            input logic [LEN_W-1:0] l);
        int n;
        cmd_we = we; cmd_addr = a; cmd_stride = s; cmd_len = l; cmd_valid = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nvec++;
        if (n >= 20) begin
            nerr++;
            $display("FAIL cmd_accept: cmd_ready never seen, required within 20 cycles");
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        @(posedge clk); #1;
        nvec++;
        if (done_cnt == base) begin
            nerr++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL rst_cmd_ready: got %b need 0", cmd_ready); end
        nvec++; if ({busy, done, err, msel} !== 4'b0) begin nerr++; $display("FAIL rst_status: got %b need 0000", {busy, done, err, msel}); end
        nvec++; if ({data_req, data_we, data_be, data_addr, data_wdata} !== '0) begin nerr++; $display("FAIL rst_bus: req=%b addr=%h need all 0", data_req, data_addr); end
        nvec++; if ({rd_valid, rd_data, wr_ready} !== '0) begin nerr++; $display("FAIL rst_streams: rd_valid=%b rd_data=%h wr_ready=%b need 0", rd_valid, rd_data, wr_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL idle_cmd_ready: got %b need 1", cmd_ready); end
    endtask

    task automatic test_load();
        logic [31:0] exp_d [4];
        int ba, br, bd;
        exp_d[0] = 32'hA1A1_0001; exp_d[1] = 32'hB2B2_0002;
        exp_d[2] = 32'hC3C3_0003; exp_d[3] = 32'hD4D4_0004;
        for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4*i)] = exp_d[i];
        gnt_stall = 1'b0; rd_ready = 1'b1;
        ba = addr_log.size(); br = rd_log.size(); bd = done_cnt;
        send_cmd(1'b0, 32'h1000, 32'd4, 8'd4);
        wait_done(bd, 60);
        nvec++; if (addr_log.size() - ba != 4) begin nerr++; $display("FAIL load_grants: got %0d need 4", addr_log.size() - ba); end
        for (int i = 0; i < 4 && ba + i < addr_log.size(); i++) begin
            nvec++; if (addr_log[ba+i] !== 32'h1000 + 32'(4*i) || be_log[ba+i] !== 4'hF) begin
                nerr++; $display("FAIL load_addr%0d: got %h be %h need %h be f", i, addr_log[ba+i], be_log[ba+i], 32'h1000 + 32'(4*i)); end
        end
        nvec++; if (rd_log.size() - br != 4) begin nerr++; $display("FAIL load_words: got %0d need 4", rd_log.size() - br); end
        for (int i = 0; i < 4 && br + i < rd_log.size(); i++) begin
            nvec++; if (rd_log[br+i] !== exp_d[i]) begin nerr++; $display("FAIL load_data%0d: got %h need %h", i, rd_log[br+i], exp_d[i]); end
        end
        nvec++; if (gnt_cyc.size() > ba && gnt_cyc[ba] != acc_cyc + 1) begin nerr++; $display("FAIL load_req_lat: got %0d need %0d", gnt_cyc[ba], acc_cyc + 1); end
        nvec++; if (rd_cyc.size() > br && rd_cyc[br] != acc_cyc + 3) begin nerr++; $display("FAIL load_rd_lat: got %0d need %0d", rd_cyc[br], acc_cyc + 3); end
        nvec++; if (done_cnt - bd != 1 || done_err !== 1'b0) begin nerr++; $display("FAIL load_done: got cnt %0d err %b need 1 err 0", done_cnt - bd, done_err); end
    endtask

    task automatic test_store();
        logic [31:0] w [3];
        logic [31:0] a [3];
        int ba, bd, brv, n;
        w[0] = 32'h1111_AAAA; w[1] = 32'h2222_BBBB; w[2] = 32'h3333_CCCC;
        a[0] = 32'h2000; a[1] = 32'h1FF8; a[2] = 32'h1FF0;
        gnt_stall = 1'b1;
        ba = addr_log.size(); bd = done_cnt; brv = rv_cnt;
        send_cmd(1'b1, 32'h2000, 32'hFFFF_FFF8, 8'd3);
        for (int i = 0; i < 3; i++) begin
            repeat (i + 1) @(posedge clk);
            #1;
            wr_valid = 1'b1; wr_data = w[i];
            n = 0;
            while (n < 30) begin
                @(negedge clk);
                if (wr_ready) break;
                n++;
            end
            @(posedge clk); #1;
            wr_valid = 1'b0;
            nvec++; if (n >= 30) begin nerr++; $display("FAIL store_hs%0d: wr_ready never seen", i); end
        end
        wait_done(bd, 60);
        gnt_stall = 1'b0;
        nvec++; if (addr_log.size() - ba != 3) begin nerr++; $display("FAIL store_grants: got %0d need 3", addr_log.size() - ba); end
        for (int i = 0; i < 3 && ba + i < addr_log.size(); i++) begin
            nvec++; if (addr_log[ba+i] !== a[i] || be_log[ba+i] !== 4'hF) begin
                nerr++; $display("FAIL store_addr%0d: got %h be %h need %h be f", i, addr_log[ba+i], be_log[ba+i], a[i]); end
            nvec++; if (!wmem.exists(a[i]) || wmem[a[i]] !== w[i]) begin
                nerr++; $display("FAIL store_data%0d: word at %h missing or wrong, need %h", i, a[i], w[i]); end
        end
        nvec++; if (wr_bad != 0) begin nerr++; $display("FAIL store_wr_ready: got %0d stray pulses need 0", wr_bad); end
        nvec++; if (stab_err != 0) begin nerr++; $display("FAIL req_stable: got %0d changes before grant need 0", stab_err); end
        nvec++; if (rv_cnt - brv != 3) begin nerr++; $display("FAIL store_acks: got %0d need 3", rv_cnt - brv); end
        nvec++; if (done_cyc != last_rv_cyc + 2 || done_err !== 1'b0) begin
            nerr++; $display("FAIL store_done: got cyc %0d err %b need cyc %0d err 0", done_cyc, done_err, last_rv_cyc + 2); end
    endtask

    task automatic test_backpressure();
        int ba, br, bd;
        for (int i = 0; i < 6; i++) mem[32'h3000 + 32'(4*i)] = 32'hB000_0000 + 32'(i);
        gnt_stall = 1'b0; rd_ready = 1'b0;
        ba = addr_log.size(); br = rd_log.size(); bd = done_cnt;
        send_cmd(1'b0, 32'h3000, 32'd4, 8'd6);
        repeat (10) @(posedge clk);
        #1;
        nvec++; if (addr_log.size() - ba != MAX_OUTST) begin nerr++; $display("FAIL bp_grants: got %0d need %0d", addr_log.size() - ba, MAX_OUTST); end
        nvec++; if ({data_req, rd_valid, busy} !== 3'b011) begin nerr++; $display("FAIL bp_stall: req/rd_valid/busy got %b need 011", {data_req, rd_valid, busy}); end
        rd_ready = 1'b1;
        wait_done(bd, 80);
        nvec++; if (addr_log.size() - ba != 6) begin nerr++; $display("FAIL bp_total: got %0d need 6", addr_log.size() - ba); end
        nvec++; if (rd_log.size() - br != 6) begin nerr++; $display("FAIL bp_words: got %0d need 6", rd_log.size() - br); end
        for (int i = 0; i < 6 && br + i < rd_log.size(); i++) begin
            nvec++; if (rd_log[br+i] !== 32'hB000_0000 + 32'(i)) begin
                nerr++; $display("FAIL bp_data%0d: got %h need %h", i, rd_log[br+i], 32'hB000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_errors();
        int ba, bd;
        ba = addr_log.size();
        bd = done_cnt;
        send_cmd(1'b0, 32'h1002, 32'd4, 8'd4);
        wait_done(bd, 10);
        nvec++; if (done_cyc != acc_cyc + 1 || done_err !== 1'b1) begin
            nerr++; $display("FAIL err_addr: got done cyc %0d err %b need cyc %0d err 1", done_cyc, done_err, acc_cyc + 1); end
        bd = done_cnt;
        send_cmd(1'b1, 32'h1000, 32'd6, 8'd2);
        wait_done(bd, 10);
        nvec++; if (done_err !== 1'b1) begin nerr++; $display("FAIL err_stride: got err %b need 1", done_err); end
        bd = done_cnt;
        send_cmd(1'b0, 32'h1000, 32'd4, 8'd0);
        wait_done(bd, 10);
        nvec++; if (done_cyc != acc_cyc + 1 || done_err !== 1'b0) begin
            nerr++; $display("FAIL len0: got done cyc %0d err %b need cyc %0d err 0", done_cyc, done_err, acc_cyc + 1); end
        nvec++; if (addr_log.size() != ba) begin nerr++; $display("FAIL err_no_bus: got %0d grants need 0", addr_log.size() - ba); end
    endtask

    task automatic test_wrap();
        logic [31:0] a [3];
        int ba, br, bd;
        a[0] = 32'hFFFF_FFF8; a[1] = 32'hFFFF_FFFC; a[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) mem[a[i]] = 32'h5A00_0000 + 32'(i);
        rd_ready = 1'b1;
        ba = addr_log.size(); br = rd_log.size(); bd = done_cnt;
        send_cmd(1'b0, 32'hFFFF_FFF8, 32'd4, 8'd3);
        wait_done(bd, 40);
        for (int i = 0; i < 3; i++) begin
            nvec++; if (ba + i >= addr_log.size() || addr_log[ba+i] !== a[i]) begin
                nerr++; $display("FAIL wrap_addr%0d: need %h (got %0d grants)", i, a[i], addr_log.size() - ba); end
        end
        nvec++; if (rd_log.size() - br != 3 || rd_log[br+2] !== 32'h5A00_0002) begin
            nerr++; $display("FAIL wrap_data: got %0d words need 3 ending 5a000002", rd_log.size() - br); end
    endtask

    task automatic test_reset_midop();
        int br, bd;
        rd_ready = 1'b1; gnt_stall = 1'b0;
        bd = done_cnt;
        send_cmd(1'b0, 32'h1000, 32'd4, 8'd8);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        nvec++; if ({busy, msel, done, cmd_ready} !== 4'b0) begin nerr++; $display("FAIL midrst_status: got %b need 0000", {busy, msel, done, cmd_ready}); end
        nvec++; if ({data_req, data_addr, data_be, rd_valid, rd_data} !== '0) begin
            nerr++; $display("FAIL midrst_bus: req=%b addr=%h rd_valid=%b need 0", data_req, data_addr, rd_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        br = rd_log.size();
        send_cmd(1'b0, 32'h1000, 32'd4, 8'd2);
        wait_done(bd, 40);
        nvec++; if (rd_log.size() - br != 2 || rd_log[br] !== 32'hA1A1_0001 || rd_log[br+1] !== 32'hB2B2_0002) begin
            nerr++; $display("FAIL midrst_rerun: got %0d words need 2 (a1a10001,b2b20002)", rd_log.size() - br); end
        nvec++; if (done_cnt - bd != 1 || done_err !== 1'b0) begin nerr++; $display("FAIL midrst_done: got %0d need 1 err 0", done_cnt - bd); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_backpressure();
        test_errors();
        test_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
